regfile_write_port: RTL

REGFILE_WRITE_PORT -- requirements
Module: regfile_write_port

---
 rtl/regfile_pkg.sv | 15 +
 rtl/decoder5_32.sv | 17 +
 rtl/regfile_write_port.sv | 77 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit register file write path.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;
    localparam int ZERO_REG = 31;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    typedef logic [DATA_W-1:0]         reg_word_t;
    // Packed so the array flattens directly onto regs_out: word i at [64i+63:64i].
    typedef reg_word_t [NUM_REGS-1:0]  reg_array_t;

endpackage

// File: rtl/decoder5_32.sv
// 5-to-32 one-hot decoder; all outputs low while en is low.
module decoder5_32
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0]   sel,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_port.sv
// Two-stage register-file write port: capture, then one-hot commit into 31 storage words.
// Optional REGFILE_BYPASS_EN forwards the pending write onto regs_out one edge early.
module regfile_write_port
    import regfile_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         RegWrite,
    input  logic [ADDR_W-1:0]            WriteRegister,
    input  logic [DATA_W-1:0]            WriteData,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         pending
);

    logic [ADDR_W-1:0]   pend_addr;
    logic [DATA_W-1:0]   pend_data;
    logic                capture;
    logic [NUM_REGS-1:0] wr_onehot;
    logic                unused_zero_we;
    reg_word_t           store [NUM_REGS-1];
    reg_array_t          view;

    // Stage 1: capture; writes to the hardwired-zero register never become pending.
    assign capture = RegWrite && (WriteRegister != ZERO_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            pending <= capture;
            if (capture) begin
                pend_addr <= WriteRegister;
                pend_data <= WriteData;
            end
        end
    end

    // Stage 2: commit the pending write through the one-hot decode.
    decoder5_32 u_dec (
        .sel    (pend_addr),
        .en     (pending),
        .onehot (wr_onehot)
    );

    assign unused_zero_we = wr_onehot[ZERO_REG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                store[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (wr_onehot[i]) begin
                    store[i] <= pend_data;
                end
            end
        end
    end

    always_comb begin
        view = '0;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            view[i] = store[i];
        end
`ifdef REGFILE_BYPASS_EN
        if (pending && (pend_addr != ZERO_ADDR)) begin
            view[pend_addr] = pend_data;
        end
`endif
    end

    assign regs_out = view;

endmodule
